// File: rtl/gray_counter_n.sv
// rtl/gray_counter_n.sv - parametrised up/down Gray-code counter with load, sticky wrap flags and carry pulse
//
// Purpose:
//   Counts in reflected binary Gray code, one step per enabled clock edge,
//   in either direction. The count is held as binary; the Gray value is
//   computed from the next binary value and registered alongside it, so
//   o_output and o_bin_out always describe the same count and never glitch.
//
// Parameters:
//   WIDTH    - counter width in bits (must be 2 or more)
//   SATURATE - 0: wrap at the ends, 1: hold at the end value
//
// Ports:
//   i_clk          in   1      rising-edge clock
//   i_reset        in   1      asynchronous active-high reset, clears all state
//   i_en           in   1      count enable
//   i_up           in   1      direction, 1 = increment, 0 = decrement
//   i_load         in   1      synchronous load of i_load_value, beats i_en
//   i_load_value   in   WIDTH  binary value to load
//   i_clr_flag     in   1      synchronous clear of the sticky flags
//   o_output       out  WIDTH  current count, Gray code
//   o_bin_out      out  WIDTH  current count, binary
//   o_overflow     out  1      sticky, set by an up-step at the maximum
//   o_underflow    out  1      sticky, set by a down-step at zero
//   o_carry        out  1      one-cycle pulse after any wrap or saturation

module gray_counter_n #(
  parameter int WIDTH    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_clr_flag,
  output logic [WIDTH-1:0] o_output,
  output logic [WIDTH-1:0] o_bin_out,
  output logic             o_overflow,
  output logic             o_underflow,
  output logic             o_carry
);

  localparam logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};

  // Registered state
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_overflow;
  logic             r_underflow;
  logic             r_carry;

  // Next-state values
  logic [WIDTH-1:0] w_next_bin;
  logic [WIDTH-1:0] w_next_gray;
  logic             w_ovf_event;
  logic             w_unf_event;
  logic             w_next_overflow;
  logic             w_next_underflow;

  // Reflected binary: each bit is the XOR of itself and the next-higher bit.
  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Step selection. Load wins over counting; a wrap event is flagged at
  // either end regardless of SATURATE, only the resulting value differs.
  always_comb begin
    w_next_bin  = r_bin;
    w_ovf_event = 1'b0;
    w_unf_event = 1'b0;
    if (i_load) begin
      w_next_bin = i_load_value;
    end else if (i_en) begin
      if (i_up) begin
        if (r_bin == MAX_COUNT) begin
          w_ovf_event = 1'b1;
          w_next_bin  = SATURATE ? MAX_COUNT : ZERO;
        end else begin
          w_next_bin = r_bin + WIDTH'(1);
        end
      end else begin
        if (r_bin == ZERO) begin
          w_unf_event = 1'b1;
          w_next_bin  = SATURATE ? ZERO : MAX_COUNT;
        end else begin
          w_next_bin = r_bin - WIDTH'(1);
        end
      end
    end
  end

  assign w_next_gray = bin_to_gray(w_next_bin);

  // A wrap event on the same edge as a clear keeps its own flag set; the
  // opposite flag is still cleared.
  assign w_next_overflow  = w_ovf_event | (r_overflow  & ~i_clr_flag);
  assign w_next_underflow = w_unf_event | (r_underflow & ~i_clr_flag);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bin       <= ZERO;
      r_gray      <= ZERO;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_carry     <= 1'b0;
    end else begin
      r_bin       <= w_next_bin;
      r_gray      <= w_next_gray;
      r_overflow  <= w_next_overflow;
      r_underflow <= w_next_underflow;
      r_carry     <= w_ovf_event | w_unf_event;
    end
  end

  assign o_output    = r_gray;
  assign o_bin_out   = r_bin;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
  assign o_carry     = r_carry;

endmodule
